ring_cadence_sequencer: RTL and testbench
=========================================

# ring_cadence_sequencer

Generates the cadenced `ring` request that drives the ringer/motor control stage. On an incoming-call event it produces repeated ON/OFF bursts until the call is answered, the caller hangs up, or the burst limit expires. It reports each outcome with a one-cycle pulse and keeps a saturating missed-call count. The block sits between the call-signalling front end and the ringer/motor controller; its `ring` output connects directly to that controller's `ring` input.

## Interface
Parameters:
- ON_CYCLES, 4, clock cycles `ring` is high per burst (>=1)
- OFF_CYCLES, 8, clock cycles `ring` is low between bursts (>=1)
- MAX_BURSTS, 5, ON bursts before the call is declared missed (>=1)

Ports:
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high; reset is synchronous and active-high
- call_start  input  1  single-cycle incoming-call request
- answer  input  1  user answered (level or pulse; sampled each cycle)
- cancel  input  1  caller hung up
- missed_clr  input  1  clears missed_count
- ring  output  1  registered ring request to the ringer/motor controller
- active  output  1  high while state is RING_ON or RING_OFF
- answered  output  1  one-cycle pulse: call answered
- missed  output  1  one-cycle pulse: call missed (timeout or cancel)
- missed_count  output  8  saturating missed-call counter

## Operation
- States: IDLE, RING_ON, RING_OFF. Phase counter width is $clog2(max(ON_CYCLES,OFF_CYCLES)). Burst counter width is $clog2(MAX_BURSTS)+1.
- IDLE: when `call_start`=1, go to RING_ON and clear both counters. All other inputs are ignored except `missed_clr`.
- RING_ON: `ring`=1. When the phase counter reaches ON_CYCLES-1:
  - if burst count = MAX_BURSTS-1: go to IDLE and pulse `missed` (timeout);
  - otherwise increment the burst count, clear the phase counter, and go to RING_OFF.
- RING_OFF: `ring`=0. When the phase counter reaches OFF_CYCLES-1, go to RING_ON.
- Terminating events in RING_ON or RING_OFF, highest priority first:
  - `answer`: go to IDLE and pulse `answered`.
  - `cancel`: go to IDLE and pulse `missed`.
  - burst-limit timeout (see RING_ON).
- `answer` and `cancel` in the same cycle: answered only.
- `answer` on the final ON cycle: answered, no missed.
- `call_start` while active: ignored; no restart, no queueing.
- `missed_count`:
  - increments on each `missed` pulse and saturates at 255;
  - `missed_clr` has priority, so a clear and an increment in the same cycle give 0.
- Reset mid-ring: every output is 0 on the next cycle, no `missed` or `answered` pulse is generated, and the state is IDLE.

## Timing
- All outputs are registered. Reset values: `ring`=0, `active`=0, `answered`=0, `missed`=0, `missed_count`=0.
- `call_start` sampled in cycle t gives `ring`=1 and `active`=1 from cycle t+1.
- Burst k (0-based) has `ring` high in cycles t+1+k·(ON+OFF) through t+k·(ON+OFF)+ON.
- Timeout: in cycle t+(MAX_BURSTS-1)·(ON+OFF)+ON+1, `ring`=0, `active`=0, and `missed`=1 for exactly that cycle.
- `answer`/`cancel` sampled in cycle c: `ring`=0, `active`=0, and the matching pulse appear in cycle c+1.
- A new `call_start` is accepted in the first IDLE cycle, i.e. the same cycle the outcome pulse is high.
- `missed_count` updates in the same cycle its `missed` pulse is visible.

## Configuration
- `RING_MISSED_COUNT_EN`
  - Defined: the `missed_count` register and `missed_clr` behave as specified.
  - Undefined: `missed_count` is tied to 0, `missed_clr` is ignored, and no counter flops are generated.
  - The `missed` pulse and all other behaviour are identical in both builds. Ports exist in both builds.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=8, MAX_BURSTS=5, with `call_start` at cycle t.
- Reset held, then released -> all outputs 0. `call_start` during reset -> no ring.
- Cadence -> `ring`=1 in cycles t+1..t+4, 0 in t+5..t+12, 1 in t+13..t+16. `active`=1 throughout.
- No answer -> last burst covers cycles t+49..t+52. At t+53: `ring`=0, `active`=0, `missed`=1, `missed_count`=1. A second `call_start` during ringing has no effect.
- `answer` at t+7 (first OFF phase) -> `answered`=1 at t+8, `ring` stays 0, `missed_count` unchanged. `answer` and `cancel` together at t+2 -> `answered` only.
- `answer` at t+52 (final ON cycle) -> `answered`=1, `missed`=0 at t+53. `reset` at t+3 -> `ring`=0 at t+4, no pulses.
- Cancel-driven misses:
  - 256 misses -> `missed_count`=255;
  - `missed_clr` coinciding with a `missed` pulse -> 0;
  - with `RING_MISSED_COUNT_EN` undefined -> `missed_count` stays 0.

Source files
------------

// File: rtl/ring_cadence_sequencer.sv
// ring_cadence_sequencer
// Cadenced ring request generator for the ringer/motor controller.
// An incoming call produces ON/OFF bursts until it is answered, cancelled,
// or the burst limit runs out. Each outcome is reported with a one-cycle
// pulse, and all outputs are registered.
// Optional feature macro: RING_MISSED_COUNT_EN. When it is defined, a
// saturating missed-call counter with a clear input is built. When it is
// not defined, missed_count is tied to 0 and missed_clr is ignored.
module ring_cadence_sequencer #(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 8,
   parameter int MAX_BURSTS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       call_start,
   input  logic       answer,
   input  logic       cancel,
   input  logic       missed_clr,
   output logic       ring,
   output logic       active,
   output logic       answered,
   output logic       missed,
   output logic [7:0] missed_count
);

   localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   // Keep the phase counter at least 1 bit wide when both phases are 1 cycle long
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int BU_W   = $clog2(MAX_BURSTS) + 1;

   localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYCLES - 1);
   localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYCLES - 1);
   localparam logic [BU_W-1:0] BU_LAST  = BU_W'(MAX_BURSTS - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RING_ON  = 2'd1;
   localparam logic [1:0] S_RING_OFF = 2'd2;

   logic [1:0]      state, state_nxt;
   logic [PH_W-1:0] phase, phase_nxt;
   logic [BU_W-1:0] burst, burst_nxt;
   logic            answered_nxt, missed_nxt;

   // Next-state logic. The terminating events are checked in priority
   // order: answer, then cancel, then the burst-limit timeout.
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      burst_nxt    = burst;
      answered_nxt = 1'b0;
      missed_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (call_start) begin
               state_nxt = S_RING_ON;
               phase_nxt = '0;
               burst_nxt = '0;
            end
         end
         S_RING_ON, S_RING_OFF: begin
            if (answer) begin
               state_nxt    = S_IDLE;
               answered_nxt = 1'b1;
            end else if (cancel) begin
               state_nxt  = S_IDLE;
               missed_nxt = 1'b1;
            end else if (state == S_RING_ON) begin
               if (phase == ON_LAST) begin
                  if (burst == BU_LAST) begin
                     state_nxt  = S_IDLE;
                     missed_nxt = 1'b1;
                  end else begin
                     burst_nxt = burst + 1'b1;
                     phase_nxt = '0;
                     state_nxt = S_RING_OFF;
                  end
               end else begin
                  phase_nxt = phase + 1'b1;
               end
            end else begin
               if (phase == OFF_LAST) begin
                  phase_nxt = '0;
                  state_nxt = S_RING_ON;
               end else begin
                  phase_nxt = phase + 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters and registered outputs. The outputs are derived from
   // the next state, so ring and active line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         phase    <= '0;
         burst    <= '0;
         ring     <= 1'b0;
         active   <= 1'b0;
         answered <= 1'b0;
         missed   <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         burst    <= burst_nxt;
         ring     <= (state_nxt == S_RING_ON);
         active   <= (state_nxt != S_IDLE);
         answered <= answered_nxt;
         missed   <= missed_nxt;
      end
   end

`ifdef RING_MISSED_COUNT_EN
   logic [7:0] cnt_q;

   // Saturating missed-call counter. A clear wins over a simultaneous increment.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= 8'd0;
      else if (missed_clr)
         cnt_q <= 8'd0;
      else if (missed_nxt && (cnt_q != 8'hFF))
         cnt_q <= cnt_q + 8'd1;
   end

   assign missed_count = cnt_q;
`else
   logic unused_missed_clr;
   assign unused_missed_clr = missed_clr;
   assign missed_count      = 8'd0;
`endif

endmodule

// File: tb/tb_ring_cadence_sequencer.sv
// tb_ring_cadence_sequencer
// Randomized and directed checks against a timeline model of the ring cadence.
module tb_ring_cadence_sequencer;

   localparam int ON   = 4;
   localparam int OFF  = 8;
   localparam int MAXB = 5;
   localparam int PER  = ON + OFF;
   localparam int LAST = (MAXB - 1) * PER + ON;   // final ON cycle, relative to call_start
`ifdef RING_MISSED_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       call_start = 1'b0, answer = 1'b0, cancel = 1'b0, missed_clr = 1'b0;
   logic       ring, active, answered, missed;
   logic [7:0] missed_count;

   int n_tests = 0;
   int n_fail  = 0;

   // The model tracks whether a call is ringing and how many cycles have
   // elapsed since call_start, which is enough to derive the expected outputs.
   bit m_act = 0, m_ans = 0, m_mis = 0;
   int m_el = 0, m_cnt = 0;

   ring_cadence_sequencer #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_BURSTS(MAXB)) dut (
      .clk(clk), .reset(reset), .call_start(call_start), .answer(answer),
      .cancel(cancel), .missed_clr(missed_clr), .ring(ring), .active(active),
      .answered(answered), .missed(missed), .missed_count(missed_count)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] exp_vec();
      logic r;
      r = m_act && (((m_el - 1) % PER) < ON);
      return {r, m_act, m_ans, m_mis, 8'(m_cnt)};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {ring, active, answered, missed, missed_count};
   endfunction

   task automatic model_step(input bit cs, ans, can, clr, rst);
      m_ans = 0; m_mis = 0;
      if (rst) begin
         m_act = 0; m_el = 0; m_cnt = 0;
         return;
      end
      if (m_act) begin
         if (ans)               begin m_act = 0; m_ans = 1; end
         else if (can)          begin m_act = 0; m_mis = 1; end
         else if (m_el == LAST) begin m_act = 0; m_mis = 1; end
         else m_el++;
      end else if (cs) begin
         m_act = 1; m_el = 1;
      end
      if (CNT_EN) begin
         if (clr) m_cnt = 0;
         else if (m_mis && m_cnt < 255) m_cnt++;
      end
   endtask

   // Drive one cycle of inputs, wait for the edge, then advance the model.
   task automatic cyc(input bit cs, ans, can, clr, rst);
      call_start = cs; answer = ans; cancel = can; missed_clr = clr; reset = rst;
      @(posedge clk); #1;
      model_step(cs, ans, can, clr, rst);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 1, 1, 1);
         n_tests++;
         if (dut_vec() !== 12'h000) begin
            n_fail++; $display("FAIL reset_hold: got %h want 000", dut_vec());
         end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0);
         n_tests++;
         if (dut_vec() !== 12'h000) begin
            n_fail++; $display("FAIL reset_release: got %h want 000", dut_vec());
         end
      end
   endtask

   task automatic test_cadence_timeout();
      cyc(1, 0, 0, 0, 0);               // now observing t+1
      for (int k = 1; k <= LAST + 1; k++) begin
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL cadence t+%0d: got %h want %h", k, dut_vec(), exp_vec());
         end
         if (k <= 16) begin
            n_tests++;
            if (ring !== ((k <= 4) || (k >= 13)) || active !== 1'b1) begin
               n_fail++; $display("FAIL cadence_ring t+%0d: got ring=%b active=%b", k, ring, active);
            end
         end
         if (k == LAST + 1) begin
            n_tests++;
            if ({ring, active, missed, missed_count} !== {3'b001, 8'(CNT_EN)}) begin
               n_fail++; $display("FAIL timeout: got r%b a%b m%b c%0d want r0 a0 m1 c%0d",
                                  ring, active, missed, missed_count, CNT_EN);
            end
         end
         if (k <= LAST) cyc(k == 20, 0, 0, 0, 0);  // call_start mid-ring must be ignored
      end
      cyc(0, 0, 0, 0, 0);
      n_tests++;
      if (dut_vec() !== {4'b0000, 8'(CNT_EN)}) begin
         n_fail++; $display("FAIL after_timeout: got %h want %h", dut_vec(), {4'b0000, 8'(CNT_EN)});
      end
   endtask

   task automatic test_answer();
      logic [7:0] c0;
      c0 = missed_count;
      cyc(1, 0, 0, 0, 0);
      repeat (6) cyc(0, 0, 0, 0, 0);   // observing t+7 (OFF phase)
      cyc(0, 1, 0, 0, 0);              // answer sampled at t+7
      n_tests++;
      if ({ring, active, answered, missed} !== 4'b0010 || missed_count !== c0) begin
         n_fail++; $display("FAIL answer_off: got %h want %h", dut_vec(), {4'b0010, c0});
      end
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);              // t+1
      cyc(0, 0, 0, 0, 0);              // t+2
      cyc(0, 1, 1, 0, 0);              // answer and cancel together
      n_tests++;
      if ({ring, active, answered, missed} !== 4'b0010) begin
         n_fail++; $display("FAIL answer_cancel: got %b want 0010", {ring, active, answered, missed});
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_final_answer_and_reset();
      cyc(1, 0, 0, 0, 0);
      repeat (LAST - 1) cyc(0, 0, 0, 0, 0);  // observing t+52
      n_tests++;
      if (ring !== 1'b1) begin
         n_fail++; $display("FAIL final_on: got ring=%b want 1", ring);
      end
      cyc(0, 1, 0, 0, 0);
      n_tests++;
      if ({ring, active, answered, missed} !== 4'b0010) begin
         n_fail++; $display("FAIL final_answer: got %b want 0010", {ring, active, answered, missed});
      end
      cyc(1, 0, 0, 0, 0);              // new call accepted on the pulse cycle: t+1
      n_tests++;
      if ({ring, active} !== 2'b11) begin
         n_fail++; $display("FAIL restart: got %b want 11", {ring, active});
      end
      cyc(0, 0, 0, 0, 0);              // t+2
      cyc(0, 0, 0, 0, 0);              // t+3
      cyc(0, 0, 0, 0, 1);              // reset sampled at t+3
      n_tests++;
      if (dut_vec() !== 12'h000) begin
         n_fail++; $display("FAIL reset_mid: got %h want 000", dut_vec());
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_saturation();
      cyc(0, 0, 0, 1, 0);
      for (int i = 0; i < 256; i++) begin
         cyc(1, 0, 0, 0, 0);
         cyc(0, 0, 1, 0, 0);
         n_tests++;
         if (missed !== 1'b1 || missed_count !== 8'(m_cnt)) begin
            n_fail++; $display("FAIL cancel_miss %0d: got m%b c%0d want m1 c%0d", i, missed, missed_count, m_cnt);
         end
      end
      n_tests++;
      if (missed_count !== (CNT_EN ? 8'd255 : 8'd0)) begin
         n_fail++; $display("FAIL saturate: got %0d want %0d", missed_count, CNT_EN ? 255 : 0);
      end
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0);              // clear coincides with the miss
      n_tests++;
      if (missed !== 1'b1 || missed_count !== 8'd0) begin
         n_fail++; $display("FAIL clr_vs_miss: got m%b c%0d want m1 c0", missed, missed_count);
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 40) == 0,
             ($urandom % 64) == 0, ($urandom % 500) == 0);
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_cadence_timeout();
      test_answer();
      test_final_answer_and_reset();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
